// File: rtl/control_unit_pipeline.sv
// Control-word pipeline (D->E->M->W) with ARM condition evaluation in E against the NZCV register.
// Define CU_PERF_CNT_EN to add the saturating cond_fail_cnt output and its CNT_W parameter.
module control_unit_pipeline #(
  parameter logic FLUSH_VAL = 1'b0
`ifdef CU_PERF_CNT_EN
  ,
  parameter int   CNT_W     = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCSD,
  input  logic             BranchD,
  input  logic             RegWD,
  input  logic             MemWD,
  input  logic             MemtoRegD,
  input  logic             ALUSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [1:0]       FlagWD,
  input  logic [3:0]       CondD,
  input  logic [3:0]       ALUFlagsE,
  input  logic             FlushE,
  output logic [2:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic             BranchTakenE,
  output logic             MemtoRegE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegW,
  output logic             RegWriteW,
  output logic             PCSrcW,
`ifdef CU_PERF_CNT_EN
  output logic [CNT_W-1:0] cond_fail_cnt,
`endif
  output logic [3:0]       FlagsQ
);

  logic       pcs_e, branch_e, regw_e, memw_e, memtoreg_e, alusrc_e;
  logic [1:0] flagw_e;
  logic [2:0] alu_control_e;
  logic [3:0] cond_e;
  logic       cond_ex_e;
  logic       regw_gated_e, memw_gated_e, pcs_gated_e;
  logic       regw_m, memw_m, memtoreg_m, pcs_m;
  logic       regw_w, memtoreg_w, pcs_w;
  logic [3:0] flags;
  logic       n_flag, z_flag, c_flag, v_flag;

  // A flush clears only the bits that can cause side effects; datapath selects pass through.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcs_e         <= 1'b0;
      branch_e      <= 1'b0;
      regw_e        <= 1'b0;
      memw_e        <= 1'b0;
      memtoreg_e    <= 1'b0;
      alusrc_e      <= 1'b0;
      flagw_e       <= 2'b00;
      alu_control_e <= 3'b000;
      cond_e        <= 4'b0000;
    end else begin
      alu_control_e <= ALUControlD;
      alusrc_e      <= ALUSrcD;
      cond_e        <= CondD;
      pcs_e         <= FlushE ? FLUSH_VAL : PCSD;
      branch_e      <= FlushE ? FLUSH_VAL : BranchD;
      regw_e        <= FlushE ? FLUSH_VAL : RegWD;
      memw_e        <= FlushE ? FLUSH_VAL : MemWD;
      memtoreg_e    <= FlushE ? FLUSH_VAL : MemtoRegD;
      flagw_e       <= FlushE ? {2{FLUSH_VAL}} : FlagWD;
    end
  end

  assign {n_flag, z_flag, c_flag, v_flag} = flags;

  always_comb begin
    cond_ex_e = 1'b0;
    case (cond_e)
      4'b0000: cond_ex_e = z_flag;
      4'b0001: cond_ex_e = !z_flag;
      4'b0010: cond_ex_e = c_flag;
      4'b0011: cond_ex_e = !c_flag;
      4'b0100: cond_ex_e = n_flag;
      4'b0101: cond_ex_e = !n_flag;
      4'b0110: cond_ex_e = v_flag;
      4'b0111: cond_ex_e = !v_flag;
      4'b1000: cond_ex_e = c_flag && !z_flag;
      4'b1001: cond_ex_e = !c_flag || z_flag;
      4'b1010: cond_ex_e = (n_flag == v_flag);
      4'b1011: cond_ex_e = (n_flag != v_flag);
      4'b1100: cond_ex_e = !z_flag && (n_flag == v_flag);
      4'b1101: cond_ex_e = z_flag || (n_flag != v_flag);
      4'b1110: cond_ex_e = 1'b1;
      default: cond_ex_e = 1'b0;
    endcase
  end

  assign regw_gated_e = regw_e & cond_ex_e;
  assign memw_gated_e = memw_e & cond_ex_e;
  assign pcs_gated_e  = pcs_e & cond_ex_e;

  // Flags are written at the end of E so the very next instruction already sees them.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else begin
      if (flagw_e[1] && cond_ex_e) flags[3:2] <= ALUFlagsE[3:2];
      if (flagw_e[0] && cond_ex_e) flags[1:0] <= ALUFlagsE[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regw_m     <= 1'b0;
      memw_m     <= 1'b0;
      memtoreg_m <= 1'b0;
      pcs_m      <= 1'b0;
      regw_w     <= 1'b0;
      memtoreg_w <= 1'b0;
      pcs_w      <= 1'b0;
    end else begin
      regw_m     <= regw_gated_e;
      memw_m     <= memw_gated_e;
      memtoreg_m <= memtoreg_e;
      pcs_m      <= pcs_gated_e;
      regw_w     <= regw_m;
      memtoreg_w <= memtoreg_m;
      pcs_w      <= pcs_m;
    end
  end

`ifdef CU_PERF_CNT_EN
  logic valid_e;

  // Bubbles from flush or reset are tracked so they are not counted as failed conditions.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e       <= 1'b0;
      cond_fail_cnt <= '0;
    end else begin
      valid_e <= !FlushE;
      if (valid_e && !cond_ex_e && (cond_fail_cnt != '1))
        cond_fail_cnt <= cond_fail_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

  assign ALUControlE  = alu_control_e;
  assign ALUSrcE      = alusrc_e;
  assign BranchTakenE = branch_e & cond_ex_e;
  assign MemtoRegE    = memtoreg_e;
  assign RegWriteM    = regw_m;
  assign MemWriteM    = memw_m;
  assign MemtoRegW    = memtoreg_w;
  assign RegWriteW    = regw_w;
  assign PCSrcW       = pcs_w;
  assign FlagsQ       = flags;

endmodule
